// File: rtl/clk_mon_pkg.sv
// rtl/clk_mon_pkg.sv - shared states and derived timing constants for the clock period monitor
package clk_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } clk_mon_state_t;

    // Half of the nominal clk_in period, in system cycles.
    function automatic int clk_mon_half(input int sys_freq, input int exp_freq);
        return sys_freq / (exp_freq * 2);
    endfunction

    function automatic int clk_mon_nominal(input int sys_freq, input int exp_freq);
        return 2 * clk_mon_half(sys_freq, exp_freq);
    endfunction

    // No rising edge for this many cycles means the monitored clock is gone.
    function automatic int clk_mon_timeout(input int sys_freq, input int exp_freq);
        return 4 * clk_mon_half(sys_freq, exp_freq);
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - two-flop synchroniser with registered previous value and edge strobes
//   clk    : destination clock
//   reset  : asynchronous active-low reset
//   din    : asynchronous input
//   rise   : synchronised 0->1 transition (one cycle)
//   fall   : synchronised 1->0 transition (one cycle)
module sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise = sync_q & ~prev_q;
    assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/clock_period_monitor.sv
// rtl/clock_period_monitor.sv - measures period/high time of a slow async clock and flags tolerance and loss
//   clk          : system clock
//   reset        : asynchronous active-low reset
//   meas_en      : measurement enable, 0 returns to IDLE
//   clk_in       : monitored asynchronous clock
//   period_out   : last complete period in system cycles
//   high_out     : high time within that period (0 if no fall was seen)
//   period_valid : one-cycle strobe when period_out/high_out update
//   freq_ok      : last period within nominal +/- TOLERANCE
//   clk_lost     : no rising edge within the timeout window
//   min_period   : smallest period since arming (CLK_MON_STATS_EN), else 0
//   max_period   : largest period since arming (CLK_MON_STATS_EN), else 0
// Optional statistics are built when CLK_MON_STATS_EN is defined.
module clock_period_monitor
    import clk_mon_pkg::*;
#(
    parameter int SYSTEM_FREQ   = 100000000,
    parameter int EXPECTED_FREQ = 50000,
    parameter int TOLERANCE     = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             meas_en,
    input  logic             clk_in,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             period_valid,
    output logic             freq_ok,
    output logic             clk_lost,
    output logic [CNT_W-1:0] min_period,
    output logic [CNT_W-1:0] max_period
);

    localparam int NOMINAL = clk_mon_nominal(SYSTEM_FREQ, EXPECTED_FREQ);
    localparam int TIMEOUT = clk_mon_timeout(SYSTEM_FREQ, EXPECTED_FREQ);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W:0]   NOMINAL_C = (CNT_W+1)'(NOMINAL);
    localparam logic [CNT_W:0]   TOL_C     = (CNT_W+1)'(TOLERANCE);

    // The counter must be able to reach TIMEOUT without wrapping.
    generate
        if (64'(TIMEOUT) >= (64'd1 << CNT_W)) begin : g_bad_cfg
            $error("clock_period_monitor: TIMEOUT does not fit in CNT_W bits");
        end
    endgenerate

    logic rise;
    logic fall;

    sync_edge_detect u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (clk_in),
        .rise  (rise),
        .fall  (fall)
    );

    clk_mon_state_t   state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] high_cap_q, high_cap_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             pv_q, pv_d;
    logic             ok_q, ok_d;
    logic             lost_q, lost_d;

    // One bit wider so the tolerance difference never wraps.
    logic [CNT_W:0] cnt_inc;
    logic [CNT_W:0] per_diff;
    logic           in_tol;

    assign cnt_inc  = {1'b0, cnt_q} + (CNT_W+1)'(1);
    assign per_diff = (cnt_inc >= NOMINAL_C) ? (cnt_inc - NOMINAL_C) : (NOMINAL_C - cnt_inc);
    assign in_tol   = (per_diff <= TOL_C);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            high_cap_q <= '0;
            period_q   <= '0;
            high_q     <= '0;
            pv_q       <= 1'b0;
            ok_q       <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            high_cap_q <= high_cap_d;
            period_q   <= period_d;
            high_q     <= high_d;
            pv_q       <= pv_d;
            ok_q       <= ok_d;
            lost_q     <= lost_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        high_cap_d = high_cap_q;
        period_d   = period_q;
        high_d     = high_q;
        pv_d       = 1'b0;
        ok_d       = ok_q;
        lost_d     = lost_q;

        if (!meas_en) begin
            // Abandon any partial period; reported values hold.
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d   = '0;
                    state_d = ARM;
                end
                ARM: begin
                    if (rise) begin
                        // Start of the first complete period.
                        cnt_d      = '0;
                        high_cap_d = '0;
                        state_d    = MEASURE;
                    end else if (cnt_q >= TIMEOUT_C) begin
                        lost_d = 1'b1;
                    end else begin
                        cnt_d = cnt_inc[CNT_W-1:0];
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_d   = cnt_inc[CNT_W-1:0];
                        high_d     = high_cap_q;
                        pv_d       = 1'b1;
                        ok_d       = in_tol;
                        lost_d     = 1'b0;
                        cnt_d      = '0;
                        high_cap_d = '0;
                    end else if (cnt_inc >= {1'b0, TIMEOUT_C}) begin
                        lost_d  = 1'b1;
                        ok_d    = 1'b0;
                        cnt_d   = '0;
                        state_d = ARM;
                    end else begin
                        cnt_d = cnt_inc[CNT_W-1:0];
                        if (fall) begin
                            high_cap_d = cnt_inc[CNT_W-1:0];
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign period_out   = period_q;
    assign high_out     = high_q;
    assign period_valid = pv_q;
    assign freq_ok      = ok_q;
    assign clk_lost     = lost_q;

`ifdef CLK_MON_STATS_EN
    logic [CNT_W-1:0] min_q;
    logic [CNT_W-1:0] max_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            min_q <= '1;
            max_q <= '0;
        end else if (meas_en && (state_q == IDLE)) begin
            // Fresh statistics each time measurement is (re)armed.
            min_q <= '1;
            max_q <= '0;
        end else if (pv_d) begin
            if (period_d < min_q) begin
                min_q <= period_d;
            end
            if (period_d > max_q) begin
                max_q <= period_d;
            end
        end
    end

    assign min_period = min_q;
    assign max_period = max_q;
`else
    assign min_period = '0;
    assign max_period = '0;
`endif

endmodule

// File: tb/tb_clock_period_monitor.sv
// tb/tb_clock_period_monitor.sv - directed self-checking bench for clock_period_monitor
module tb_clock_period_monitor;

    localparam int CNT_W = 16;

    logic             clk;
    logic             reset;
    logic             meas_en;
    logic             clk_in;
    logic [CNT_W-1:0] period_out;
    logic [CNT_W-1:0] high_out;
    logic             period_valid;
    logic             freq_ok;
    logic             clk_lost;
    logic [CNT_W-1:0] min_period;
    logic [CNT_W-1:0] max_period;

    clock_period_monitor #(
        .SYSTEM_FREQ   (100000000),
        .EXPECTED_FREQ (50000),
        .TOLERANCE     (4),
        .CNT_W         (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .meas_en      (meas_en),
        .clk_in       (clk_in),
        .period_out   (period_out),
        .high_out     (high_out),
        .period_valid (period_valid),
        .freq_ok      (freq_ok),
        .clk_lost     (clk_lost),
        .min_period   (min_period),
        .max_period   (max_period)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_rise_cyc = 0;
    int b2b      = 0;
    logic pv_prev = 1'b0;

    typedef struct {
        int per;
        int hi;
        int ok;
        int cyc;
    } rep_t;

    rep_t rep_q[$];

    always @(posedge clk) cyc = cyc + 1;

    // Capture every report away from the active edge.
    always @(negedge clk) begin
        if (period_valid === 1'b1) begin
            rep_t r;
            r.per = int'(period_out);
            r.hi  = int'(high_out);
            r.ok  = int'(freq_ok);
            r.cyc = cyc;
            rep_q.push_back(r);
            if (pv_prev) b2b = b2b + 1;
        end
        pv_prev = (period_valid === 1'b1);
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clk_in period: rising edge, hi cycles high, lo cycles low.
    task automatic drive_period(input int hi, input int lo);
        clk_in = 1'b1;
        last_rise_cyc = cyc;
        repeat (hi) @(negedge clk);
        clk_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic expect_report(input string tag, input int per, input int hi, input int ok,
                                 output int pcyc);
        pcyc = 0;
        check({tag, "_present"}, int'(rep_q.size() > 0), 1);
        if (rep_q.size() > 0) begin
            rep_t r;
            r = rep_q.pop_front();
            check({tag, "_period"}, r.per, per);
            check({tag, "_high"}, r.hi, hi);
            check({tag, "_ok"}, r.ok, ok);
            pcyc = r.cyc;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_period"}, int'(period_out), 0);
        check({tag, "_high"}, int'(high_out), 0);
        check({tag, "_pv"}, int'(period_valid), 0);
        check({tag, "_ok"}, int'(freq_ok), 0);
        check({tag, "_lost"}, int'(clk_lost), 0);
    endtask

    initial begin
        int c0, c1, c2;
        int found;
        int lost_cyc;

        reset   = 1'b0;
        meas_en = 1'b0;
        clk_in  = 1'b0;
        repeat (5) @(negedge clk);
        check_all_zero("reset");

        reset   = 1'b1;
        meas_en = 1'b1;
        @(negedge clk);

        // Ideal 50 kHz, 50% duty: first rise arms, next three close periods.
        repeat (4) drive_period(1000, 1000);
        expect_report("ideal0", 2000, 1000, 1, c0);
        expect_report("ideal1", 2000, 1000, 1, c1);
        expect_report("ideal2", 2000, 1000, 1, c2);
        check("ideal_spacing01", c1 - c0, 2000);
        check("ideal_spacing12", c2 - c1, 2000);
        check("ideal_lost", int'(clk_lost), 0);

        // Tolerance edges and 30/70 duty.
        drive_period(1002, 1002);
        expect_report("ideal3", 2000, 1000, 1, c0);
        drive_period(1000, 1005);
        expect_report("tol_2004", 2004, 1002, 1, c0);
        drive_period(600, 1400);
        expect_report("tol_2005", 2005, 1000, 0, c0);
        drive_period(600, 1400);
        expect_report("duty30", 2000, 600, 1, c0);

        // Clock stops low: loss exactly TIMEOUT after the detected rise (+3 sync).
        check("lost_before", int'(clk_lost), 0);
        found = 0;
        lost_cyc = 0;
        for (int i = 0; i < 3000 && found == 0; i++) begin
            @(negedge clk);
            if (clk_lost === 1'b1) begin
                found = 1;
                lost_cyc = cyc;
            end
        end
        check("lost_seen", found, 1);
        if (found == 1) check("lost_latency", lost_cyc - last_rise_cyc, 4003);
        check("lost_freq_ok", int'(freq_ok), 0);
        check("lost_period_hold", int'(period_out), 2000);
        check("lost_no_report", rep_q.size(), 0);

        // Restart: first rise only arms, first full period clears loss.
        drive_period(1000, 1000);
        check("restart_arm_no_report", rep_q.size(), 0);
        check("restart_lost_still", int'(clk_lost), 1);
        drive_period(1000, 1000);
        expect_report("restart", 2000, 1000, 1, c0);
        check("restart_lost_clear", int'(clk_lost), 0);

        // meas_en toggled mid-period: partial period dropped, outputs hold.
        clk_in = 1'b1;
        repeat (500) @(negedge clk);
        expect_report("pre_toggle", 2000, 1000, 1, c0);
        meas_en = 1'b0;
        repeat (10) @(negedge clk);
        check("toggle_hold_period", int'(period_out), 2000);
        meas_en = 1'b1;
        repeat (490) @(negedge clk);
        clk_in = 1'b0;
        repeat (1000) @(negedge clk);
        drive_period(995, 995);
        check("toggle_no_partial", rep_q.size(), 0);
        check("toggle_hold_high", int'(high_out), 1000);
        check("toggle_lost", int'(clk_lost), 0);
`ifdef CLK_MON_STATS_EN
        check("stats_min_init", int'(min_period), 65535);
        check("stats_max_init", int'(max_period), 0);
`else
        check("stats_min_tied", int'(min_period), 0);
        check("stats_max_tied", int'(max_period), 0);
`endif
        drive_period(1005, 1005);
        expect_report("p1990", 1990, 995, 0, c0);
        drive_period(1000, 1000);
        expect_report("p2010", 2010, 1005, 0, c0);
`ifdef CLK_MON_STATS_EN
        check("stats_min", int'(min_period), 1990);
        check("stats_max", int'(max_period), 2010);
`else
        check("stats_min_off", int'(min_period), 0);
        check("stats_max_off", int'(max_period), 0);
`endif

        // Async reset mid-period, between clock edges.
        @(negedge clk);
        #2 reset = 1'b0;
        #1 check_all_zero("async_reset");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        drive_period(1000, 1000);
        check("post_reset_arm_no_report", rep_q.size(), 0);
        check("post_reset_period_zero", int'(period_out), 0);
        drive_period(700, 1300);
        expect_report("post_reset", 2000, 1000, 1, c0);

        repeat (10) @(negedge clk);
        check("no_back_to_back", b2b, 0);
        check("no_stray_reports", rep_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_period_monitor.md
Name: clock_period_monitor

Overview:
- Receive-side counterpart to the clock divider: samples an asynchronous divided or slow clock (`clk_in`) in the system clock domain.
- Measures the period and high time of `clk_in` in system cycles.
- Flags whether the measured frequency is within tolerance of the expected frequency, and flags loss of the clock.
- Sits beside any divided-clock consumer as a health monitor; results feed status registers.

Parameters:
- SYSTEM_FREQ, 100000000, system clock frequency in Hz
- EXPECTED_FREQ, 50000, nominal `clk_in` frequency in Hz
- TOLERANCE, 4, allowed |period − nominal| in system cycles
- CNT_W, 16, width of the measurement counter and of the period/high outputs

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- meas_en  input  1  measurement enable; 0 forces IDLE
- clk_in  input  1  asynchronous monitored clock
- period_out  output  CNT_W  last measured period, in system cycles
- high_out  output  CNT_W  high time of the last measured period, in system cycles
- period_valid  output  1  one-cycle pulse when period_out/high_out update
- freq_ok  output  1  last period within NOMINAL ± TOLERANCE
- clk_lost  output  1  no rising edge within TIMEOUT cycles

Behaviour:
- Derived constants:
  - HALF = SYSTEM_FREQ/(EXPECTED_FREQ*2)
  - NOMINAL = 2*HALF (2000 at defaults)
  - TIMEOUT = 4*HALF
  - Elaboration error if TIMEOUT ≥ 2^CNT_W.
- Reset (async assert, sync release): all outputs 0; state IDLE; counter 0; synchroniser flops 0.
- Input path:
  - 2-flop synchroniser on `clk_in`, then a registered previous value.
  - rise = sync & ~prev; fall = ~sync & prev.
  - Edge-to-detect latency: 3 clk cycles.
- FSM:
  - IDLE: counter held at 0. meas_en=1 → ARM.
  - ARM: wait for first rise; counter cleared to 0 on rise → MEASURE. Counter increments in ARM; count ≥ TIMEOUT → clk_lost=1, stay in ARM, counter holds.
  - MEASURE, each cycle:
    - rise → period_out ≤ cnt+1; high_out ≤ captured high; period_valid=1 next cycle; freq_ok ≤ (|cnt+1 − NOMINAL| ≤ TOLERANCE); clk_lost ≤ 0; cnt ≤ 0.
    - fall → high capture ≤ cnt+1.
    - otherwise cnt ≤ cnt+1.
    - cnt+1 reaches TIMEOUT with no rise → clk_lost=1, freq_ok=0, no period_valid, → ARM with cnt=0.
  - meas_en=0 in any state → IDLE next cycle. Outputs hold their last values; no pulse in progress is emitted.
- Boundaries:
  - First period after ARM is always complete; no partial period is ever reported.
  - A period with no fall (stuck high, then rise) is impossible by construction.
  - If no fall is seen since the last rise, high_out reports 0.
  - Counter never wraps, because TIMEOUT < 2^CNT_W.
  - Reset mid-measurement discards all state.
- period_valid pulses are never back-to-back. Minimum spacing is 2 cycles, because the synchronised input cannot toggle faster.

Optional Feature:
- Macro: CLK_MON_STATS_EN.
- When defined:
  - Extra outputs min_period and max_period (CNT_W each).
  - Updated on every period_valid.
  - Initialised to all-ones (min) and 0 (max) at reset and on the IDLE→ARM transition.
- When undefined:
  - Both outputs exist, tied to 0.
  - No extra registers.

Decomposition:
- Package clk_mon_pkg holds:
  - the state enum (IDLE, ARM, MEASURE);
  - functions computing HALF, NOMINAL and TIMEOUT from the parameters.
- Sub-module: sync_edge_detect (2-flop synchroniser, previous-value register, rise/fall outputs). It is reusable by other cross-domain inputs.

Test Plan:
- Ideal 50 kHz `clk_in` (1000 high / 1000 low cycles), meas_en=1 → after the first full period: period_valid pulse; period_out=2000; high_out=1000; freq_ok=1; clk_lost=0; pulse repeats every 2000 cycles.
- Period 2004 (edge of tolerance) → freq_ok=1. Period 2005 → freq_ok=0.
- 30/70 duty: 600 high / 1400 low → period_out=2000, high_out=600.
- `clk_in` stops low after a valid period → clk_lost=1 exactly TIMEOUT=4000 cycles after the last rise; no period_valid. Restart clock → first full period clears clk_lost and reports 2000.
- reset=0 asserted mid-period (async, between clk edges) → all outputs 0 immediately. After release, the first report arrives only after ARM plus one full period.
- meas_en toggled 1→0→1 mid-period → no period_valid for the partial period; outputs hold until the next complete period. With CLK_MON_STATS_EN: min/max re-initialise, then track periods 1990/2010 as min=1990, max=2010.
